// File: rtl/video_wb_arbiter_if.sv
// Bus bundle for video_wb_arbiter: the two video master ports plus the shared system-bus master port.
// slave = arbiter view, master = environment view (video masters and interconnect).
interface video_wb_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic              m0_STB_I, m0_CYC_I, m0_LOCK_I, m0_WE_I;
   logic [3:0]        m0_SEL_I;
   logic [ADDR_W-1:0] m0_ADR_I;
   logic [DATA_W-1:0] m0_DAT_I;
   logic              m0_ACK_O, m0_ERR_O;
   logic [DATA_W-1:0] m0_DAT_O;

   logic              m1_STB_I, m1_CYC_I, m1_LOCK_I, m1_WE_I;
   logic [3:0]        m1_SEL_I;
   logic [ADDR_W-1:0] m1_ADR_I;
   logic [DATA_W-1:0] m1_DAT_I;
   logic              m1_ACK_O, m1_ERR_O;
   logic [DATA_W-1:0] m1_DAT_O;

   logic              p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O;
   logic [3:0]        p_wb_SEL_O;
   logic [ADDR_W-1:0] p_wb_ADR_O;
   logic [DATA_W-1:0] p_wb_DAT_O;
   logic              p_wb_ACK_I, p_wb_ERR_I;
   logic [DATA_W-1:0] p_wb_DAT_I;

   modport slave (
      input  m0_STB_I, m0_CYC_I, m0_LOCK_I, m0_WE_I, m0_SEL_I, m0_ADR_I, m0_DAT_I,
      output m0_ACK_O, m0_ERR_O, m0_DAT_O,
      input  m1_STB_I, m1_CYC_I, m1_LOCK_I, m1_WE_I, m1_SEL_I, m1_ADR_I, m1_DAT_I,
      output m1_ACK_O, m1_ERR_O, m1_DAT_O,
      output p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O, p_wb_ADR_O, p_wb_DAT_O,
      input  p_wb_ACK_I, p_wb_ERR_I, p_wb_DAT_I
   );

   modport master (
      output m0_STB_I, m0_CYC_I, m0_LOCK_I, m0_WE_I, m0_SEL_I, m0_ADR_I, m0_DAT_I,
      input  m0_ACK_O, m0_ERR_O, m0_DAT_O,
      output m1_STB_I, m1_CYC_I, m1_LOCK_I, m1_WE_I, m1_SEL_I, m1_ADR_I, m1_DAT_I,
      input  m1_ACK_O, m1_ERR_O, m1_DAT_O,
      input  p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O, p_wb_ADR_O, p_wb_DAT_O,
      output p_wb_ACK_I, p_wb_ERR_I, p_wb_DAT_I
   );
endinterface

// File: rtl/video_wb_arbiter.sv
// Two-port Wishbone master arbiter (port 0 video-in store, port 1 video-out load), whole-cycle
// round-robin grants with a sticky starvation flag. Optional bus watchdog via `WB_WATCHDOG_EN.
module video_wb_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_HOLD = 1024,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              RST,
   video_wb_arbiter_if.slave bus,
   output logic [1:0]        grant,
   output logic              starve,
   input  logic              starve_clr
);
   localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

   state_t            r_state;
   logic [1:0]        r_grant;
   logic              r_last;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic              r_starve;

   logic w_g0, w_g1, w_rel0, w_rel1, w_waiting, w_starve_set;
   logic w_wd_err, w_stb_kill;

   assign w_g0      = (r_state == GNT0);
   assign w_g1      = (r_state == GNT1);
   // LOCK keeps the grant across a CYC drop
   assign w_rel0    = w_g0 && !bus.m0_CYC_I && !bus.m0_LOCK_I;
   assign w_rel1    = w_g1 && !bus.m1_CYC_I && !bus.m1_LOCK_I;
   assign w_waiting = (w_g0 && bus.m1_CYC_I) || (w_g1 && bus.m0_CYC_I);
   assign w_starve_set = w_waiting && !w_rel0 && !w_rel1 &&
                         (r_hold_cnt == HOLD_W'(MAX_HOLD - 1));

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_state    <= IDLE;
         r_grant    <= 2'b00;
         r_last     <= 1'b1;
         r_hold_cnt <= '0;
         r_starve   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.m0_CYC_I && (!bus.m1_CYC_I || r_last)) begin
                  r_state <= GNT0;
                  r_grant <= 2'b01;
               end else if (bus.m1_CYC_I) begin
                  r_state <= GNT1;
                  r_grant <= 2'b10;
               end
            end
            GNT0: begin
               if (w_rel0) begin
                  r_last <= 1'b0;
                  if (bus.m1_CYC_I) begin
                     r_state <= GNT1;
                     r_grant <= 2'b10;
                  end else begin
                     r_state <= IDLE;
                     r_grant <= 2'b00;
                  end
               end
            end
            GNT1: begin
               if (w_rel1) begin
                  r_last <= 1'b1;
                  if (bus.m0_CYC_I) begin
                     r_state <= GNT0;
                     r_grant <= 2'b01;
                  end else begin
                     r_state <= IDLE;
                     r_grant <= 2'b00;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_grant <= 2'b00;
            end
         endcase

         // hold_cnt measures how long the non-granted port has been kept waiting
         if (w_rel0 || w_rel1 || !w_waiting)
            r_hold_cnt <= '0;
         else if (r_hold_cnt != HOLD_W'(MAX_HOLD))
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);

         if (w_starve_set)
            r_starve <= 1'b1;
         else if (starve_clr)
            r_starve <= 1'b0;
      end
   end

`ifdef WB_WATCHDOG_EN
   localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_wd_err;
   logic            r_wd_wait;

   // After a timeout the strobe stays parked until the owner abandons its cycle
   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         r_wd_cnt  <= '0;
         r_wd_err  <= 1'b0;
         r_wd_wait <= 1'b0;
      end else begin
         r_wd_err <= 1'b0;
         if (r_state == IDLE || w_rel0 || w_rel1) begin
            r_wd_cnt  <= '0;
            r_wd_wait <= 1'b0;
         end else if (bus.p_wb_ACK_I || bus.p_wb_ERR_I) begin
            r_wd_cnt <= '0;
         end else if (bus.p_wb_STB_O) begin
            if (r_wd_cnt == WD_W'(TIMEOUT - 1)) begin
               r_wd_cnt  <= '0;
               r_wd_err  <= 1'b1;
               r_wd_wait <= 1'b1;
            end else begin
               r_wd_cnt <= r_wd_cnt + WD_W'(1);
            end
         end
      end
   end

   assign w_wd_err   = r_wd_err;
   assign w_stb_kill = r_wd_err || r_wd_wait;
`else
   logic w_unused_timeout;

   assign w_unused_timeout = (TIMEOUT == 0);
   assign w_wd_err         = 1'b0;
   assign w_stb_kill       = 1'b0;
`endif

   // Granted port passes straight through; idle bus is driven to zero
   assign bus.p_wb_CYC_O  = (w_g0 && bus.m0_CYC_I)  || (w_g1 && bus.m1_CYC_I);
   assign bus.p_wb_STB_O  = ((w_g0 && bus.m0_STB_I) || (w_g1 && bus.m1_STB_I)) && !w_stb_kill;
   assign bus.p_wb_LOCK_O = (w_g0 && bus.m0_LOCK_I) || (w_g1 && bus.m1_LOCK_I);
   assign bus.p_wb_WE_O   = (w_g0 && bus.m0_WE_I)   || (w_g1 && bus.m1_WE_I);
   assign bus.p_wb_SEL_O  = w_g0 ? bus.m0_SEL_I : (w_g1 ? bus.m1_SEL_I : 4'h0);
   assign bus.p_wb_ADR_O  = w_g0 ? bus.m0_ADR_I : (w_g1 ? bus.m1_ADR_I : ADDR_W'(0));
   assign bus.p_wb_DAT_O  = w_g0 ? bus.m0_DAT_I : (w_g1 ? bus.m1_DAT_I : DATA_W'(0));

   assign bus.m0_ACK_O = w_g0 && bus.p_wb_ACK_I;
   assign bus.m1_ACK_O = w_g1 && bus.p_wb_ACK_I;
   assign bus.m0_ERR_O = w_g0 && (bus.p_wb_ERR_I || w_wd_err);
   assign bus.m1_ERR_O = w_g1 && (bus.p_wb_ERR_I || w_wd_err);
   assign bus.m0_DAT_O = (w_g0 || w_g1) ? bus.p_wb_DAT_I : DATA_W'(0);
   assign bus.m1_DAT_O = (w_g0 || w_g1) ? bus.p_wb_DAT_I : DATA_W'(0);

   assign grant  = r_grant;
   assign starve = r_starve;
endmodule

// File: tb/tb_video_wb_arbiter.sv
// Self-checking bench for video_wb_arbiter: per-cycle vector table for arbitration/passthrough,
// scoreboarded write burst, starvation, watchdog/no-watchdog and async reset sequences.
module tb_video_wb_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam logic [31:0] DAT_IN = 32'hD0D0_5A5A;
`ifdef WB_WATCHDOG_EN
   localparam bit WD_ON = 1'b1;
`else
   localparam bit WD_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       RST;
   logic       starve_clr;
   logic [1:0] grant;
   logic       starve;
   int         n_total = 0;
   int         n_pass  = 0;

   video_wb_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   video_wb_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(8), .TIMEOUT(4)) dut (
      .clk(clk), .RST(RST), .bus(bus), .grant(grant), .starve(starve), .starve_clr(starve_clr)
   );

   always #5 clk = ~clk;

   // in = {c0,s0,l0,c1,s1,ack,err}; cs = {cyc,stb}; rsp = {m0_ack,m1_ack,m0_err,m1_err}
   typedef struct {
      logic [6:0]  in;
      logic [1:0]  g;
      logic [1:0]  cs;
      logic [31:0] adr;
      logic [3:0]  rsp;
   } vec_t;
   typedef struct {
      logic [31:0] adr;
      logic [31:0] dat;
   } beat_t;

   vec_t  tbl [21];
   beat_t sb [$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      starve_clr = 1'b0;
      {bus.m0_CYC_I, bus.m0_STB_I, bus.m0_LOCK_I, bus.m1_CYC_I, bus.m1_STB_I, bus.m1_LOCK_I} = '0;
      {bus.p_wb_ACK_I, bus.p_wb_ERR_I} = '0;
      repeat (2) @(posedge clk);
      #1 RST = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL sim_timeout: time limit reached");
      $fatal(1);
   end

   initial begin
      beat_t b;
      int    beat;
      bit    acked, present;

      tbl[0]  = '{7'b1101110, 2'b00, 2'b00, 32'h0,    4'b0000};
      tbl[1]  = '{7'b1101100, 2'b01, 2'b11, 32'hA000, 4'b0000};
      tbl[2]  = '{7'b1101110, 2'b01, 2'b11, 32'hA000, 4'b1000};
      tbl[3]  = '{7'b1001100, 2'b01, 2'b10, 32'hA000, 4'b0000};
      tbl[4]  = '{7'b0001100, 2'b01, 2'b00, 32'hA000, 4'b0000};
      tbl[5]  = '{7'b0001100, 2'b10, 2'b11, 32'hB000, 4'b0000};
      tbl[6]  = '{7'b1101000, 2'b10, 2'b10, 32'hB000, 4'b0000};
      tbl[7]  = '{7'b1101000, 2'b10, 2'b10, 32'hB000, 4'b0000};
      tbl[8]  = '{7'b1101101, 2'b10, 2'b11, 32'hB000, 4'b0001};
      tbl[9]  = '{7'b1101110, 2'b10, 2'b11, 32'hB000, 4'b0100};
      tbl[10] = '{7'b1100000, 2'b10, 2'b00, 32'hB000, 4'b0000};
      tbl[11] = '{7'b1111100, 2'b01, 2'b11, 32'hA000, 4'b0000};
      tbl[12] = '{7'b0011100, 2'b01, 2'b00, 32'hA000, 4'b0000};
      tbl[13] = '{7'b1101100, 2'b01, 2'b11, 32'hA000, 4'b0000};
      tbl[14] = '{7'b0001100, 2'b01, 2'b00, 32'hA000, 4'b0000};
      tbl[15] = '{7'b0000000, 2'b10, 2'b00, 32'hB000, 4'b0000};
      tbl[16] = '{7'b0000011, 2'b00, 2'b00, 32'h0,    4'b0000};
      tbl[17] = '{7'b1101100, 2'b00, 2'b00, 32'h0,    4'b0000};
      tbl[18] = '{7'b1101100, 2'b01, 2'b11, 32'hA000, 4'b0000};
      tbl[19] = '{7'b0000000, 2'b01, 2'b00, 32'hA000, 4'b0000};
      tbl[20] = '{7'b0000000, 2'b00, 2'b00, 32'h0,    4'b0000};

      bus.m0_WE_I = 1'b1; bus.m0_SEL_I = 4'hF; bus.m0_ADR_I = 32'hA000; bus.m0_DAT_I = 32'h11;
      bus.m1_WE_I = 1'b0; bus.m1_SEL_I = 4'h3; bus.m1_ADR_I = 32'hB000; bus.m1_DAT_I = 32'h22;
      bus.p_wb_DAT_I = DAT_IN;

      // Reset holds everything at zero even with requests and a stray ACK present
      RST = 1'b1; starve_clr = 1'b0;
      {bus.m0_CYC_I, bus.m0_STB_I, bus.m0_LOCK_I, bus.m1_CYC_I, bus.m1_STB_I, bus.m1_LOCK_I} = 6'b110000;
      {bus.p_wb_ACK_I, bus.p_wb_ERR_I} = 2'b10;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_grant", 64'(grant), 0);
      check("rst_starve", 64'(starve), 0);
      check("rst_bus", 64'({bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_WE_O, bus.p_wb_ADR_O}), 0);
      check("rst_m0_ack", 64'(bus.m0_ACK_O), 0);

      do_reset();
      for (int i = 0; i < 21; i++) begin
         @(posedge clk); #1;
         {bus.m0_CYC_I, bus.m0_STB_I, bus.m0_LOCK_I, bus.m1_CYC_I, bus.m1_STB_I,
          bus.p_wb_ACK_I, bus.p_wb_ERR_I} = tbl[i].in;
         @(negedge clk);
         check($sformatf("tbl%0d_grant", i), 64'(grant), 64'(tbl[i].g));
         check($sformatf("tbl%0d_cyc_stb", i), 64'({bus.p_wb_CYC_O, bus.p_wb_STB_O}), 64'(tbl[i].cs));
         check($sformatf("tbl%0d_adr", i), 64'(bus.p_wb_ADR_O), 64'(tbl[i].adr));
         check($sformatf("tbl%0d_rsp", i),
               64'({bus.m0_ACK_O, bus.m1_ACK_O, bus.m0_ERR_O, bus.m1_ERR_O}), 64'(tbl[i].rsp));
         check($sformatf("tbl%0d_we_sel", i), 64'({bus.p_wb_WE_O, bus.p_wb_SEL_O}),
               (tbl[i].g == 2'b01) ? 64'h1F : ((tbl[i].g == 2'b10) ? 64'h03 : 64'h0));
         check($sformatf("tbl%0d_wdat", i), 64'(bus.p_wb_DAT_O),
               (tbl[i].g == 2'b01) ? 64'h11 : ((tbl[i].g == 2'b10) ? 64'h22 : 64'h0));
         check($sformatf("tbl%0d_rdat", i), 64'(bus.m1_DAT_O),
               (tbl[i].g != 2'b00) ? 64'(DAT_IN) : 64'h0);
      end
      check("tbl_starve", 64'(starve), 0);

      // 16-beat write burst from port 0, slave ACKs one cycle after each strobe
      do_reset();
      @(posedge clk); #1;
      bus.m0_CYC_I = 1'b1; bus.m0_STB_I = 1'b1;
      bus.m0_ADR_I = 32'h1000; bus.m0_DAT_I = 32'hC0DE_0000;
      sb.push_back('{32'h1000, 32'hC0DE_0000});
      @(negedge clk);
      check("burst_grant_latency", 64'(grant), 0);
      @(posedge clk); #1;
      beat = 0;
      for (int cyc = 0; cyc < 100 && beat < 16; cyc++) begin
         @(negedge clk);
         acked = 1'b0; present = 1'b0;
         check("burst_grant", 64'(grant), 64'h1);
         if (bus.p_wb_ACK_I) begin
            check("burst_m0_ack", 64'(bus.m0_ACK_O), 1);
            acked = 1'b1;
            beat++;
         end else if (bus.p_wb_CYC_O && bus.p_wb_STB_O) begin
            check("sb_nonempty", 64'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
               b = sb.pop_front();
               check("burst_adr", 64'(bus.p_wb_ADR_O), 64'(b.adr));
               check("burst_dat", 64'(bus.p_wb_DAT_O), 64'(b.dat));
               check("burst_we", 64'(bus.p_wb_WE_O), 1);
            end
            present = 1'b1;
         end
         check("burst_m1_ack", 64'(bus.m1_ACK_O), 0);
         @(posedge clk); #1;
         bus.p_wb_ACK_I = present;
         if (acked) begin
            if (beat < 16) begin
               bus.m0_ADR_I = 32'h1000 + 32'(4 * beat);
               bus.m0_DAT_I = 32'hC0DE_0000 + 32'(beat);
               sb.push_back('{bus.m0_ADR_I, bus.m0_DAT_I});
            end else begin
               bus.m0_CYC_I = 1'b0; bus.m0_STB_I = 1'b0;
            end
         end
      end
      check("burst_beats", 64'(beat), 16);
      check("burst_sb_drained", 64'(sb.size()), 0);
      @(posedge clk);
      @(negedge clk);
      check("burst_idle_grant", 64'(grant), 0);

      // Port 0 hogs the bus while port 1 waits; clear collides with set at hold=8
      do_reset();
      @(posedge clk); #1;
      bus.m0_CYC_I = 1'b1; bus.m1_CYC_I = 1'b1; bus.m1_STB_I = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         starve_clr = (k == 7 || k == 12);
         @(negedge clk);
         check($sformatf("starve_k%0d", k), 64'(starve), 64'(k >= 8 && k < 13));
      end
      check("starve_hold_grant", 64'(grant), 64'h1);
      @(posedge clk); #1 bus.m0_CYC_I = 1'b0;
      @(negedge clk);
      check("handoff_gap_cyc", 64'(bus.p_wb_CYC_O), 0);
      @(posedge clk);
      @(negedge clk);
      check("handoff_grant", 64'(grant), 64'h2);
      check("handoff_cyc", 64'(bus.p_wb_CYC_O), 1);

      // Unanswered strobe: watchdog ERR pulse when enabled, silence otherwise
      do_reset();
      @(posedge clk); #1;
      bus.m0_CYC_I = 1'b1; bus.m0_STB_I = 1'b1;
      for (int j = 1; j <= 8; j++) begin
         @(posedge clk);
         @(negedge clk);
         check($sformatf("wd_err_j%0d", j), 64'(bus.m0_ERR_O), 64'(WD_ON && j == 5));
         check($sformatf("wd_stb_j%0d", j), 64'(bus.p_wb_STB_O), 64'(!WD_ON || j < 5));
      end
      @(posedge clk); #1;
      bus.m0_CYC_I = 1'b0; bus.m0_STB_I = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("wd_release_grant", 64'(grant), 0);

      // Async reset in the middle of a granted beat
      do_reset();
      @(posedge clk); #1;
      bus.m0_CYC_I = 1'b1; bus.m0_STB_I = 1'b1;
      @(posedge clk); #1 bus.p_wb_ACK_I = 1'b1;
      @(negedge clk);
      check("midrst_pre_ack", 64'(bus.m0_ACK_O), 1);
      #1 RST = 1'b1;
      #1;
      check("midrst_bus", 64'({bus.p_wb_CYC_O, bus.p_wb_STB_O, bus.p_wb_WE_O, bus.p_wb_SEL_O,
                               bus.p_wb_ADR_O}), 0);
      check("midrst_resp", 64'({grant, bus.m0_ACK_O, bus.m0_ERR_O, bus.p_wb_DAT_O}), 0);
      do_reset();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
